// File: rtl/cmd_packet_fifo.sv
// In-order command packet buffer feeding the dataflow decoder: first-word-fall-through head, one push and one pop per cycle.
// Write-to-read latency 1 cycle; writes are refused while full (sticky overflow), and the head is held while fifo_stall is high.
module cmd_packet_fifo #(
    parameter int PACKET_W = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [PACKET_W-1:0] in_packet,
    output logic                in_ready,
    input  logic                fifo_stall,
    output logic                out_valid,
    output logic [PACKET_W-1:0] out_packet,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                overflow
);

    logic [PACKET_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                clear;
    logic                push;
    logic                pop;
    logic [PTR_W-1:0]    wr_ptr_inc;
    logic [PTR_W-1:0]    rd_ptr_inc;

    // Status is decoded from the registered count only, so no input reaches an output combinationally.
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AF_LEVEL));
    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign out_packet  = mem[rd_ptr];

    assign clear = reset || flush;
    assign push  = in_valid && in_ready && !clear;
    assign pop   = out_valid && !fifo_stall && !clear;

    // Explicit wrap so non-power-of-two depths work.
    assign wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is left uninitialised on reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_packet;
        end
    end

endmodule

// File: tb/tb_cmd_packet_fifo.sv
// Bench for cmd_packet_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_cmd_packet_fifo;

    localparam int PW = 16;
    localparam int D  = 8;
    localparam int AF = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_packet;
    logic          in_ready;
    logic          fifo_stall;
    logic          out_valid;
    logic [PW-1:0] out_packet;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;

    logic [PW-1:0] q[$];
    logic [PW-1:0] popped[$];
    logic          m_ovf = 1'b0;
    bit            model_ok = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    cmd_packet_fifo #(.PACKET_W(PW), .DEPTH(D), .AF_LEVEL(AF)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_packet(in_packet), .in_ready(in_ready),
        .fifo_stall(fifo_stall), .out_valid(out_valid), .out_packet(out_packet),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("m_count", 32'(count), 32'(n));
        chk("m_empty", 32'(empty), 32'(n == 0));
        chk("m_full", 32'(full), 32'(n == D));
        chk("m_almost_full", 32'(almost_full), 32'(n >= AF));
        chk("m_in_ready", 32'(in_ready), 32'(n < D));
        chk("m_out_valid", 32'(out_valid), 32'(n > 0));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        if (n > 0) chk("m_out_packet", 32'(out_packet), 32'(q[0]));
    endtask

    // One clock cycle: drive inputs, compare registered outputs with the model, then advance the model.
    task automatic step(input logic r, input logic f, input logic v, input logic [PW-1:0] p, input logic s);
        bit was_full;
        bit do_pop;
        reset = r; flush = f; in_valid = v; in_packet = p; fifo_stall = s;
        if (model_ok) check_model();
        if (r || f) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (q.size() == D);
            do_pop   = (q.size() > 0) && !s;
            if (v && was_full) m_ovf = 1'b1;
            if (do_pop) begin
                popped.push_back(q[0]);
                void'(q.pop_front());
            end
            if (v && !was_full) q.push_back(p);
        end
        @(posedge clk);
        #1;
        if (r) model_ok = 1'b1;
    endtask

    initial begin
        int sent;
        int cyc;
        logic [PW-1:0] pv;
        logic sv;

        // Reset for two cycles, push in cycle 3, observe in cycle 4, empty in cycle 5.
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        step(0, 0, 1, 16'h4A31, 0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_packet", 32'(out_packet), 32'h4A31);
        step(0, 0, 0, 16'h0, 0);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_no_valid", 32'(out_valid), 32'd0);

        // Stall hold.
        step(0, 0, 1, 16'h0C00, 1);
        step(0, 0, 1, 16'h8005, 1);
        step(0, 0, 1, 16'hC003, 1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_packet", 32'(out_packet), 32'h0C00);
            chk("stall_count", 32'(count), 32'd3);
            step(0, 0, 0, 16'h0, 1);
        end
        chk("release_0", 32'(out_packet), 32'h0C00);
        step(0, 0, 0, 16'h0, 0);
        chk("release_1", 32'(out_packet), 32'h8005);
        step(0, 0, 0, 16'h0, 0);
        chk("release_2", 32'(out_packet), 32'hC003);
        step(0, 0, 0, 16'h0, 0);
        chk("release_empty", 32'(empty), 32'd1);

        // Fill past full with the head stalled.
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 16'(16'h0100 + i), 1);
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= AF));
        end
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_head", 32'(out_packet), 32'h0100);

        // Drain to 5, then flush together with a write and a pop.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0);
        chk("pre_flush_count", 32'(count), 32'd5);
        chk("pre_flush_ovf", 32'(overflow), 32'd1);
        chk("pre_flush_head", 32'(out_packet), 32'h0103);
        step(0, 1, 1, 16'hDEAD, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_overflow", 32'(overflow), 32'd0);
        step(0, 0, 0, 16'h0, 0);
        chk("flush_no_store", 32'(out_valid), 32'd0);

        // Sequential stream with random stalls; in_valid high until all 40 are accepted.
        popped.delete();
        sent = 0;
        cyc = 0;
        while (popped.size() < 40 && cyc < 400) begin
            sv = 1'($urandom_range(0, 1));
            pv = 16'(sent);
            if (sent < 40 && q.size() < D) begin
                step(0, 0, 1, pv, sv);
                sent++;
            end else begin
                step(0, 0, sent < 40, pv, sv);
            end
            chk("stream_count_max", 32'(count <= 4'd8), 32'd1);
            cyc++;
        end
        chk("stream_len", 32'(popped.size()), 32'd40);
        for (int i = 0; i < 40 && i < popped.size(); i++) chk("stream_order", 32'(popped[i]), 32'(i));

        // Reset in the middle of a stalled stream.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 16'(16'hA000 + i), 1);
        chk("pre_rst_count", 32'(count), 32'd4);
        step(1, 0, 0, 16'h0, 1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        step(0, 0, 1, 16'h1234, 0);
        chk("post_rst_packet", 32'(out_packet), 32'h1234);
        chk("post_rst_only", 32'(count), 32'd1);
        step(0, 0, 0, 16'h0, 0);
        chk("post_rst_drained", 32'(empty), 32'd1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 45);
        end
        step(0, 0, 0, 16'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_packet_fifo.md
# cmd_packet_fifo

Command-packet buffer directly upstream of the dataflow decoder. It accepts command packets from the host/controller write port, stores them in order, and presents the head packet as a valid/packet pair (com_packet style) to the decoder. It holds the head stable while the decoder's combinational `fifo_stall` is high, and provides occupancy and overflow status to the controller.

## Interface
- `PACKET_W`, default 16: packet width, equal to `packet_size`. Bits [PACKET_W-1:PACKET_W-2] are the command type; the FIFO never interprets them.
- `DEPTH`, default 8: number of storage entries. Legal range is 2..64; powers of two are not required.
- `AF_LEVEL`, default 6: `almost_full` threshold, 1 ≤ AF_LEVEL ≤ DEPTH.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `flush`, input, 1: synchronous clear of all stored packets.
- `in_valid`, input, 1: write request.
- `in_packet`, input, PACKET_W: write data.
- `in_ready`, output, 1: write accepted when high; equals !full.
- `fifo_stall`, input, 1: decoder hold request; combinational from the decoder in the same cycle.
- `out_valid`, output, 1: head packet present; drives com2DPpacket.valid.
- `out_packet`, output, PACKET_W: head packet; drives com2DPpacket.packet.
- `count`, output, $clog2(DEPTH+1): stored packets.
- `full`, output, 1: count == DEPTH.
- `empty`, output, 1: count == 0.
- `almost_full`, output, 1: count ≥ AF_LEVEL.
- `overflow`, output, 1: sticky; set when in_valid && !in_ready. Cleared only by reset or flush.

## Operation
- Storage is a circular buffer `mem[DEPTH]` with a write pointer, a read pointer and a count register.
- Pointers wrap explicitly from DEPTH-1 to 0; there is no reliance on power-of-two overflow.
- Push condition: in_valid && in_ready. The packet is written to mem[wr_ptr] and wr_ptr advances.
- Pop condition: out_valid && !fifo_stall. rd_ptr advances.
- Consume semantics: the decoder takes the head in every cycle where out_valid=1 and fifo_stall=0. A stalled head must be re-presented unchanged until a non-stalled cycle.
- Output is first-word-fall-through.
  - out_packet = mem[rd_ptr], read from registered state.
  - out_valid = !empty.
  - There is no combinational path from fifo_stall, in_valid or in_packet to any output.
- in_ready, full, empty and almost_full are all decoded from the registered count only.
- Count update: count_next = count + push − pop.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, and both pointers advance.
- Full (count == DEPTH):
  - in_ready = 0.
  - A pop in the same cycle does not enable a push; in_ready is registered-count based.
  - A rejected write sets `overflow` and does not modify storage.
- Empty: out_valid = 0 and pop is impossible. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Flush has priority over push and pop in the same cycle.
  - Pointers and count go to 0, and `overflow` clears.
  - An in_valid in the flush cycle is discarded, and `overflow` is not set for it.
- Reset has the same effect as flush and has priority over everything.
  - Reset values: count=0, out_valid=0, empty=1, full=0, almost_full=0, in_ready=1, overflow=0.
  - out_packet is don't-care while out_valid=0. Memory contents are not cleared.
- Reset asserted mid-stream discards all stored packets; the first packet after reset release is the first one pushed after release.

## Timing
- Write-to-read latency is 1 cycle. A push in cycle t gives out_valid=1 in t+1 when the FIFO was empty.
- Back-to-back throughput is one push and one pop per cycle, sustained.
- Pop in cycle t: the next packet, if any, is on out_packet in t+1. If that pop emptied the FIFO, out_valid=0 in t+1.
- Stall: while fifo_stall=1, out_packet, out_valid and rd_ptr are constant. Pushes continue until full.
- Status outputs (count, full, empty, almost_full, in_ready, overflow) reflect state registered at the clock edge ending the cycle in which the event occurred.

## Test plan
- Reset then single packet:
  - Stimulus: reset for 2 cycles; push 0x4A31 in cycle 3 with fifo_stall=0.
  - Required: out_valid=1 and out_packet=0x4A31 in cycle 4; popped in cycle 4; empty=1 in cycle 5.
- Stall hold:
  - Stimulus: push 0x0C00, 0x8005, 0xC003; hold fifo_stall=1 for 10 cycles.
  - Required: out_packet stays 0x0C00 and count stays 3 throughout.
  - Then release the stall: packets appear in order, one per cycle.
- Fill and overflow (DEPTH=8, AF_LEVEL=6):
  - Stimulus: push 9 packets with fifo_stall=1.
  - Required: almost_full=1 at count 6; full=1 and in_ready=0 at count 8; the 9th write is dropped; overflow=1; count stays 8.
- Wrap-around with simultaneous push and pop:
  - Stimulus: stream 40 sequential values (0..39); fifo_stall toggles pseudo-randomly; in_valid is always high.
  - Required: the output sequence is exactly 0..39; no loss and no duplicates; count never exceeds 8.
- Flush priority:
  - Stimulus: with count=5 and overflow=1, assert flush together with in_valid and a pop.
  - Required: next cycle count=0, empty=1, overflow=0; the flush-cycle write is not stored.
- Reset mid-operation:
  - Stimulus: count=4, stalled; assert reset for 1 cycle; then push 0x1234.
  - Required: out_valid=0 in the cycle after reset; 0x1234 appears as the only packet.
